clock_divider_n: RTL
====================

# clock_divider_n

Parametrised, runtime-programmable integer clock divider producing a near-50% duty output clock from `clockin`. It is the general successor of the fixed divide-by-2 flop: the divisor N is loaded at run time, an enable gates the output, and odd divisors can be given an exact 50% duty cycle. It sits at the clock-generation edge of a design, and its `tick` output lets synchronous logic align to output periods without sampling `clockout`.

## Interface
- `WIDTH`, 8: width of divisor and counter.
- `DEFAULT_DIV`, 2: divisor active after reset; values below 2 are clamped to 2.

Ports:
- `clockin`  input  1  sole clock; all state updates on posedge, except the odd-duty flop (see Configuration).
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  high: divider runs; low: output held low, counter parked.
- `div_in`  input  WIDTH  requested divisor N.
- `div_load`  input  1  one-cycle strobe capturing `div_in` into the pending register.
- `clockout`  output  1  divided clock.
- `tick`  output  1  one-cycle pulse, high in the cycle `clockout` rises.
- `div_active`  output  WIDTH  divisor currently in use.
- `div_pending`  output  1  a loaded divisor is waiting for a period boundary.

## Operation
- State: counter `cnt` (0..N-1), posedge output flop `q_pos`, `pend_val`, `pend_flag`, `div_active`.
- Effective divisor: every captured value is clamped, so `div_in` < 2 is stored as 2.
- High length H: even N gives H = N/2. Odd N gives H = (N+1)/2 without the macro and (N-1)/2 with it.
- Each posedge with `enable`=1:
  - `q_pos` <= (`cnt` < H).
  - `tick` <= (`cnt` == 0).
  - `cnt` <= (`cnt` == N-1) ? 0 : `cnt`+1.
- Each posedge with `enable`=0: `cnt` <= 0, `q_pos` <= 0, `tick` <= 0.
- Divisor load: `div_load`=1 writes the clamped `div_in` into `pend_val` and sets `pend_flag`.
  - A second load while pending overwrites `pend_val`; the last one wins.
- Divisor apply:
  - `enable`=1 and `pend_flag`=1: applied on the wrap cycle (`cnt` == N-1). `div_active` <= `pend_val`, `pend_flag` cleared, and the next period uses the new N and H.
  - `enable`=0: a pending value is applied on the next posedge.
  - `div_load` in the same cycle as an apply: the apply uses the old `pend_val`. The new value becomes pending and `pend_flag` stays 1.
- Reset: `cnt`=0, `q_pos`=0, `tick`=0, `clockout`=0, `pend_flag`=0, `div_pending`=0, `div_active`=clamped `DEFAULT_DIV`.
  - Reset mid-period drops any pending divisor and aborts the period; no glitch extension.

## Timing
- All outputs are registered; no combinational path from inputs to outputs, except `clockout` = OR of two flops in odd mode.
- First rising edge of `clockout`: 1 posedge after the first posedge with `reset`=0 and `enable`=1. `tick` is high in that same cycle.
- Output period is exactly N `clockin` cycles, with high time H cycles (or N/2 cycles in odd mode).
- Enable deassertion: `clockout` goes low 1 posedge later (half a cycle later for the negedge flop).
- Enable reassertion: a fresh period starts with `cnt`=0.
- Divisor change takes effect at the first period boundary after the load, never mid-period. Worst-case latency from load to new period is N_old cycles.
- `div_pending` rises 1 cycle after `div_load` and falls in the cycle `div_active` updates.

## Configuration
- `CLKDIV_ODD_DUTY_EN` defined:
  - Adds flop `q_neg`, clocked on negedge `clockin`: `q_neg` <= `reset` ? 0 : `q_pos`.
  - For odd N, `clockout` = `q_pos` | `q_neg`, giving exactly N/2 cycles high.
  - For even N, `clockout` = `q_pos`, with `q_neg` ignored.
- Not defined: no negedge logic; `clockout` = `q_pos`. Odd N yields (N+1)/2 cycles high and (N-1)/2 cycles low.

## Test plan
- Reset held 3 cycles, `DEFAULT_DIV`=2 -> `clockout`=0, `div_active`=2, `div_pending`=0. After release with `enable`=1, `clockout` toggles every posedge and `tick` pulses every 2nd cycle.
- Load N=6 -> `div_active`=6 after the current period wraps. `clockout` is 3 cycles high, 3 low, period 60 ns at a 10 ns `clockin`.
- Load N=5:
  - with macro: high 25 ns, low 25 ns.
  - without macro: high 30 ns, low 20 ns.
- N=8 running, load 4 at `cnt`=2 then load 3 at `cnt`=5 -> the current 8-cycle period completes intact, then `div_active`=3. The value 4 is never applied.
- `div_in`=0, then `div_in`=1 -> `div_active`=2 in both cases, and the output is the divide-by-2 waveform.
- N=7 running, assert `reset` at `cnt`=4 with a divisor pending -> the next cycle has `clockout`=0, `div_pending`=0, `div_active`=`DEFAULT_DIV`. After release the first rising edge comes 1 cycle later.

Source files
------------

// File: rtl/clock_divider_n.sv
// clock_divider_n: runtime-programmable integer clock divider with enable, tick and pending-divisor staging.
// Latency: all outputs registered; clockout/tick rise one posedge after enable, divisor changes at a period boundary.
// Option CLKDIV_ODD_DUTY_EN: adds a negedge flop so odd divisors get an exact 50% duty cycle.
module clock_divider_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clockout,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_pending
);

  // Divide-by-0 and divide-by-1 are meaningless, so every divisor is clamped to at least 2.
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend_val;
  logic             pend_flag;
  logic             q_pos;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] high_len;
  logic             wrap;
  logic             apply;

  assign load_val = (div_in < MIN_DIV) ? MIN_DIV : div_in;
  assign last_cnt = div_active - WIDTH'(1);
  assign wrap     = (cnt == last_cnt);

  // A staged divisor lands on the wrap cycle so a period is never cut short;
  // with the divider parked there is no period to protect, so it lands at once.
  assign apply = pend_flag && (!enable || wrap);

`ifdef CLKDIV_ODD_DUTY_EN
  // Odd N: q_pos is high for (N-1)/2 cycles and the negedge copy stretches it by half a cycle.
  assign high_len = div_active >> 1;
`else
  // Odd N: the extra cycle goes to the high phase, (N+1)/2 high and (N-1)/2 low.
  assign high_len = (div_active >> 1) + {{(WIDTH-1){1'b0}}, div_active[0]};
`endif

  // Period counter, posedge output flop and the period-start tick pulse.
  always_ff @(posedge clockin) begin
    if (reset) begin
      cnt   <= '0;
      q_pos <= 1'b0;
      tick  <= 1'b0;
    end else if (enable) begin
      q_pos <= (cnt < high_len);
      tick  <= (cnt == '0);
      cnt   <= wrap ? '0 : cnt + WIDTH'(1);
    end else begin
      // Parking at zero makes re-enable start a fresh, full period.
      cnt   <= '0;
      q_pos <= 1'b0;
      tick  <= 1'b0;
    end
  end

  // Divisor staging: a load always wins over the clear of an apply in the same cycle,
  // while the apply itself still takes the value that was pending before the load.
  always_ff @(posedge clockin) begin
    if (reset) begin
      pend_val   <= DEF_DIV;
      pend_flag  <= 1'b0;
      div_active <= DEF_DIV;
    end else begin
      if (apply) begin
        div_active <= pend_val;
      end
      if (div_load) begin
        pend_val  <= load_val;
        pend_flag <= 1'b1;
      end else if (apply) begin
        pend_flag <= 1'b0;
      end
    end
  end

  assign div_pending = pend_flag;

`ifdef CLKDIV_ODD_DUTY_EN
  logic q_neg;

  // Half-cycle delayed copy of q_pos; ORed in only for odd divisors.
  always_ff @(negedge clockin) begin
    q_neg <= reset ? 1'b0 : q_pos;
  end

  assign clockout = div_active[0] ? (q_pos | q_neg) : q_pos;
`else
  assign clockout = q_pos;
`endif

endmodule
